// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI transmit scheduler.
// Holds the FSM state encoding, the MIDI status-byte ranges and small
// classification helpers used by the scheduler.
package midi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_NEXT = 2'd3
    } state_t;

    // Width of the requester index presented on grant_id
    localparam int GRANT_W = 3;

    // MIDI status byte ranges
    localparam logic [7:0] CV_LO = 8'h80;   // channel voice
    localparam logic [7:0] CV_HI = 8'hEF;
    localparam logic [7:0] SC_LO = 8'hF0;   // system common
    localparam logic [7:0] SC_HI = 8'hF7;
    localparam logic [7:0] RT_LO = 8'hF8;   // real-time
    localparam logic [7:0] RT_HI = 8'hFF;

    function automatic logic is_chan_voice(input logic [7:0] s);
        return (s >= CV_LO) && (s <= CV_HI);
    endfunction

    function automatic logic is_sys_common(input logic [7:0] s);
        return (s >= SC_LO) && (s <= SC_HI);
    endfunction

    // A zero length field still carries the status byte
    function automatic logic [1:0] eff_len(input logic [1:0] l);
        return (l == 2'd0) ? 2'd1 : l;
    endfunction

endpackage

// File: rtl/midi_tx_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index, search starts one past
// the last requester that was advanced past.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          req,
    input  logic                  advance,
    output logic [N-1:0]          grant,
    output logic [2:0]            grant_idx
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [2:0] ptr_q;
    logic [2:0] ptr_d;

    // Scan from the pointer with wrap-around and take the first pending request
    always_comb begin
        int   k;
        logic found;
        k         = 0;
        found     = 1'b0;
        grant     = '0;
        grant_idx = '0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr_q) + i;
            if (k >= N) k = k - N;
            if (!found && req[IW'(k)]) begin
                found            = 1'b1;
                grant[IW'(k)]    = 1'b1;
                grant_idx        = 3'(k);
            end
        end
    end

    // Move the pointer just past the requester that was granted
    always_comb begin
        ptr_d = ptr_q;
        if (advance && (|req)) begin
            ptr_d = (int'(grant_idx) == N - 1) ? 3'd0 : grant_idx + 3'd1;
        end
    end

    // Pointer register
    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/midi_tx_scheduler.sv
// MIDI transmit scheduler: picks one pending message round-robin, then
// feeds its bytes (status, data1, data2) one at a time to a UART byte
// transmitter, waiting for uart_done between bytes.
// Optional feature macro: MIDI_RUNNING_STATUS_EN (running-status
// compression of repeated channel-voice status bytes).
module midi_tx_scheduler
    import midi_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*8-1:0]   req_status,
    input  logic [NUM_REQ*8-1:0]   req_data1,
    input  logic [NUM_REQ*8-1:0]   req_data2,
    input  logic [NUM_REQ*2-1:0]   req_len,
    output logic                   uart_valid,
    output logic [7:0]             uart_data,
    input  logic                   uart_done,
    input  logic                   uart_idle,
    output logic                   busy,
    output logic [GRANT_W-1:0]     grant_id
);

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic                 uart_valid_q, uart_valid_d;
    logic [7:0]           uart_data_q, uart_data_d;
    logic                 busy_q, busy_d;
    logic [GRANT_W-1:0]   grant_id_q, grant_id_d;
    logic [1:0]           byte_idx_q, byte_idx_d;
    logic [7:0]           msg_status_q, msg_status_d;
    logic [7:0]           msg_d1_q, msg_d1_d;
    logic [7:0]           msg_d2_q, msg_d2_d;
    logic [1:0]           msg_len_q, msg_len_d;
`ifdef MIDI_RUNNING_STATUS_EN
    logic [7:0]           last_status_q, last_status_d;
`endif

    logic                 start;
    logic                 skip_status;
    logic [1:0]           nxt_idx;
    logic [NUM_REQ-1:0]   arb_grant;
    logic [2:0]           arb_idx;

    function automatic logic [7:0] pick_byte(input logic [1:0] idx, input logic [7:0] s,
                                             input logic [7:0] d1, input logic [7:0] d2);
        case (idx)
            2'd0:    return s;
            2'd1:    return d1;
            default: return d2;
        endcase
    endfunction

    // Requesters are only considered while idle and the UART is free
    assign start = (state_q == ST_IDLE) && (|req_valid) && uart_idle;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .advance   (start),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    // Next-state and next-output logic for the message scheduler
    always_comb begin
        state_d      = state_q;
        req_ready_d  = '0;
        uart_valid_d = uart_valid_q;
        uart_data_d  = uart_data_q;
        grant_id_d   = grant_id_q;
        byte_idx_d   = byte_idx_q;
        msg_status_d = msg_status_q;
        msg_d1_d     = msg_d1_q;
        msg_d2_d     = msg_d2_q;
        msg_len_d    = msg_len_q;
        skip_status  = 1'b0;
        nxt_idx      = byte_idx_q + 2'd1;
`ifdef MIDI_RUNNING_STATUS_EN
        last_status_d = last_status_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_LOAD;
                    req_ready_d  = arb_grant;
                    grant_id_d   = arb_idx;
                    msg_status_d = req_status[int'(arb_idx)*8 +: 8];
                    msg_d1_d     = req_data1[int'(arb_idx)*8 +: 8];
                    msg_d2_d     = req_data2[int'(arb_idx)*8 +: 8];
                    msg_len_d    = eff_len(req_len[int'(arb_idx)*2 +: 2]);
                end
            end
            ST_LOAD: begin
`ifdef MIDI_RUNNING_STATUS_EN
                skip_status = is_chan_voice(msg_status_q) && (msg_status_q == last_status_q)
                              && (msg_len_q >= 2'd2);
`endif
                byte_idx_d   = skip_status ? 2'd1 : 2'd0;
                uart_valid_d = 1'b1;
                uart_data_d  = pick_byte(byte_idx_d, msg_status_q, msg_d1_q, msg_d2_q);
                state_d      = ST_SEND;
            end
            ST_SEND: begin
                // Drop the request on the same edge done is seen so the UART never restarts
                if (uart_done) begin
                    uart_valid_d = 1'b0;
                    state_d      = ST_NEXT;
`ifdef MIDI_RUNNING_STATUS_EN
                    if (byte_idx_q == 2'd0) begin
                        if (is_chan_voice(msg_status_q))      last_status_d = msg_status_q;
                        else if (is_sys_common(msg_status_q)) last_status_d = 8'h00;
                    end
`endif
                end
            end
            ST_NEXT: begin
                if (nxt_idx < msg_len_q) begin
                    byte_idx_d   = nxt_idx;
                    uart_valid_d = 1'b1;
                    uart_data_d  = pick_byte(nxt_idx, msg_status_q, msg_d1_q, msg_d2_q);
                    state_d      = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Control state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= '0;
            uart_valid_q <= 1'b0;
            uart_data_q  <= 8'hFF;
            busy_q       <= 1'b0;
            grant_id_q   <= '0;
            byte_idx_q   <= '0;
`ifdef MIDI_RUNNING_STATUS_EN
            last_status_q <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            uart_valid_q <= uart_valid_d;
            uart_data_q  <= uart_data_d;
            busy_q       <= busy_d;
            grant_id_q   <= grant_id_d;
            byte_idx_q   <= byte_idx_d;
`ifdef MIDI_RUNNING_STATUS_EN
            last_status_q <= last_status_d;
`endif
        end
    end

    // Latched message payload; only meaningful after a LOAD
    always_ff @(posedge clk) begin
        msg_status_q <= msg_status_d;
        msg_d1_q     <= msg_d1_d;
        msg_d2_q     <= msg_d2_d;
        msg_len_q    <= msg_len_d;
    end

    assign req_ready  = req_ready_q;
    assign uart_valid = uart_valid_q;
    assign uart_data  = uart_data_q;
    assign busy       = busy_q;
    assign grant_id   = grant_id_q;

endmodule

// File: tb/tb_midi_tx_scheduler.sv
// Testbench for midi_tx_scheduler: message-level reference model
// (round-robin order, byte list per message, optional running status)
// checked against the UART byte stream and req_ready pulses.
module tb_midi_tx_scheduler;

    localparam int NUM_REQ = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*8-1:0]   req_status, req_data1, req_data2;
    logic [NUM_REQ*2-1:0]   req_len;
    logic                   uart_valid;
    logic [7:0]             uart_data;
    logic                   uart_done, uart_idle, busy;
    logic [2:0]             grant_id;

    midi_tx_scheduler #(.NUM_REQ(NUM_REQ)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_status (req_status),
        .req_data1  (req_data1),
        .req_data2  (req_data2),
        .req_len    (req_len),
        .uart_valid (uart_valid),
        .uart_data  (uart_data),
        .uart_done  (uart_done),
        .uart_idle  (uart_idle),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] m_status [NUM_REQ];
    logic [7:0] m_d1     [NUM_REQ];
    logic [7:0] m_d2     [NUM_REQ];
    logic [1:0] m_len    [NUM_REQ];
    int         m_ptr;
    logic [7:0] m_last;

    logic [7:0] exp_bytes[$];
    logic [7:0] act_bytes[$];
    int         exp_grants[$];
    int         act_grants[$];
    int         bptr, gptr;
    logic       done_prev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_req(input int i, input logic [7:0] st, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [1:0] len);
        m_status[i] = st; m_d1[i] = d1; m_d2[i] = d2; m_len[i] = len;
        req_status[i*8 +: 8] = st;
        req_data1[i*8 +: 8]  = d1;
        req_data2[i*8 +: 8]  = d2;
        req_len[i*2 +: 2]    = len;
    endtask

    task automatic new_scn();
        exp_bytes.delete(); act_bytes.delete();
        exp_grants.delete(); act_grants.delete();
        bptr = 0; gptr = 0;
    endtask

    // Bytes one message puts on the wire, with optional running-status rules
    task automatic emit_msg(input int g);
        logic [7:0] b [3];
        logic [7:0] st;
        int         n;
        int         first;
        st    = m_status[g];
        b[0]  = st; b[1] = m_d1[g]; b[2] = m_d2[g];
        n     = (m_len[g] == 2'd0) ? 1 : int'(m_len[g]);
        first = 0;
`ifdef MIDI_RUNNING_STATUS_EN
        if (st >= 8'h80 && st <= 8'hEF && st == m_last && n >= 2) first = 1;
        if (first == 0) begin
            if (st >= 8'h80 && st <= 8'hEF)      m_last = st;
            else if (st >= 8'hF0 && st <= 8'hF7) m_last = 8'h00;
        end
`endif
        for (int j = first; j < n; j++) exp_bytes.push_back(b[j]);
    endtask

    // Whole burst of held requests served in round-robin order
    task automatic model_burst(input logic [NUM_REQ-1:0] mask);
        logic [NUM_REQ-1:0] pend;
        int g;
        int k;
        pend = mask;
        while (pend != '0) begin
            g = -1;
            for (int i = 0; i < NUM_REQ; i++) begin
                k = (m_ptr + i) % NUM_REQ;
                if (g < 0 && pend[k]) g = k;
            end
            pend[g] = 1'b0;
            exp_grants.push_back(g);
            m_ptr = (g + 1) % NUM_REQ;
            emit_msg(g);
        end
    endtask

    task automatic sample_ready();
        int idx;
        idx = 0;
        if (req_ready != '0) begin
            chk("ready_onehot", $countones(req_ready), 1);
            for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) idx = i;
            if (gptr < exp_grants.size()) begin
                chk("grant_order", idx, exp_grants[gptr]);
                chk("grant_id", grant_id, exp_grants[gptr]);
            end else begin
                chk("extra_grant", gptr, exp_grants.size());
            end
            chk("busy_in_load", busy, 1);
            gptr++;
            act_grants.push_back(idx);
            req_valid[idx] = 1'b0;
        end
    endtask

    // Acts as the UART (3-cycle byte time) and checks every cycle
    task automatic run(input int max_bytes);
        int got, cyc, stall;
        logic held;
        logic [7:0] prev;
        got = 0; cyc = 0; stall = 0; held = 1'b0; prev = 8'h00;
        while (got < max_bytes && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            sample_ready();
            if (done_prev) chk("valid_drop", uart_valid, 0);
            uart_done = 1'b0;
            done_prev = 1'b0;
            if (uart_valid) begin
                chk("busy_when_valid", busy, 1);
                if (held) chk("data_stable", uart_data, prev);
                held = 1'b1; prev = uart_data; stall++;
                if (stall >= 3) begin
                    uart_done = 1'b1; done_prev = 1'b1; stall = 0; held = 1'b0;
                    act_bytes.push_back(uart_data);
                    if (bptr < exp_bytes.size()) chk("byte", uart_data, exp_bytes[bptr]);
                    else chk("extra_byte", bptr, exp_bytes.size());
                    bptr++; got++;
                end
            end else begin
                held = 1'b0;
            end
        end
        if (got < max_bytes) chk("timeout_bytes", got, max_bytes);
    endtask

    task automatic settle();
        @(negedge clk);
        sample_ready();
        if (done_prev) chk("valid_drop", uart_valid, 0);
        uart_done = 1'b0; done_prev = 1'b0;
        @(negedge clk);
        chk("busy_drop", busy, 0);
        repeat (3) begin
            @(negedge clk);
            chk("quiet_valid", uart_valid, 0);
            chk("quiet_ready", req_ready, 0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; uart_done = 1'b0; done_prev = 1'b0; req_valid = '0;
        repeat (2) @(negedge clk);
        chk("rst_uart_valid", uart_valid, 0);
        chk("rst_uart_data", uart_data, 8'hFF);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        rst = 1'b0;
        m_ptr = 0; m_last = 8'h00;
    endtask

    task automatic lit(input string name, input int pos, input logic [7:0] exp);
        if (pos < act_bytes.size()) chk(name, act_bytes[pos], exp);
        else chk({name, "_missing"}, act_bytes.size(), pos + 1);
    endtask

    task automatic lit_grant(input int pos, input int exp);
        if (pos < act_grants.size()) chk("lit_grant", act_grants[pos], exp);
        else chk("lit_grant_missing", act_grants.size(), pos + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst = 1'b1; req_valid = '0; req_status = '0; req_data1 = '0; req_data2 = '0;
        req_len = '0; uart_done = 1'b0; uart_idle = 1'b1; done_prev = 1'b0;
        m_ptr = 0; m_last = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 8'h00, 8'h00, 8'h00, 2'd0);
        do_reset();

        // Single three-byte note-on
        new_scn();
        set_req(0, 8'h90, 8'h3C, 8'h64, 2'd3);
        model_burst(4'b0001);
        req_valid = 4'b0001;
        run(exp_bytes.size());
        settle();
        lit("s1_b0", 0, 8'h90);
        lit("s1_b1", 1, 8'h3C);
        lit("s1_b2", 2, 8'h64);
        chk("s1_ready_pulses", act_grants.size(), 1);

        // Start blocked while the UART reports not idle
        new_scn();
        set_req(1, 8'hC0, 8'h05, 8'h00, 2'd2);
        uart_idle = 1'b0;
        req_valid = 4'b0010;
        repeat (5) begin
            @(negedge clk);
            chk("noidle_busy", busy, 0);
            chk("noidle_ready", req_ready, 0);
        end
        uart_idle = 1'b1;
        model_burst(4'b0010);
        run(exp_bytes.size());
        settle();
        lit("s2_b0", 0, 8'hC0);
        lit("s2_b1", 1, 8'h05);

        // Four simultaneous two-byte requests, burst twice after reset
        do_reset();
        new_scn();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 8'h90 + 8'(i), 8'h10 + 8'(i), 8'h40, 2'd2);
        model_burst(4'hF);
        req_valid = 4'hF;
        run(exp_bytes.size() - bptr);
        settle();
        model_burst(4'hF);
        req_valid = 4'hF;
        run(exp_bytes.size() - bptr);
        settle();
        for (int i = 0; i < 8; i++) lit_grant(i, i % 4);
        lit("s3_b0", 0, 8'h90);
        lit("s3_b1", 1, 8'h10);
        lit("s3_b2", 2, 8'h91);
        lit("s3_b7", 7, 8'h13);

        // Running-status sequence
        new_scn();
        set_req(0, 8'h90, 8'h3C, 8'h64, 2'd3);
        model_burst(4'b0001); req_valid = 4'b0001; run(exp_bytes.size() - bptr); settle();
        set_req(0, 8'h90, 8'h40, 8'h64, 2'd3);
        model_burst(4'b0001); req_valid = 4'b0001; run(exp_bytes.size() - bptr); settle();
        set_req(0, 8'hF8, 8'h00, 8'h00, 2'd1);
        model_burst(4'b0001); req_valid = 4'b0001; run(exp_bytes.size() - bptr); settle();
        set_req(0, 8'h90, 8'h45, 8'h64, 2'd3);
        model_burst(4'b0001); req_valid = 4'b0001; run(exp_bytes.size() - bptr); settle();
`ifdef MIDI_RUNNING_STATUS_EN
        chk("s4_count", act_bytes.size(), 8);
        lit("s4_b3", 3, 8'h40);
        lit("s4_b5", 5, 8'hF8);
        lit("s4_b6", 6, 8'h45);
`else
        chk("s4_count", act_bytes.size(), 10);
        lit("s4_b3", 3, 8'h90);
        lit("s4_b6", 6, 8'hF8);
        lit("s4_b7", 7, 8'h90);
`endif

        // Reset while data2 of 80 3C 00 is on the wire
        new_scn();
        set_req(2, 8'h80, 8'h3C, 8'h00, 2'd3);
        model_burst(4'b0100);
        req_valid = 4'b0100;
        run(2);
        w = 0;
        do begin
            @(negedge clk);
            uart_done = 1'b0; done_prev = 1'b0; w++;
        end while (!uart_valid && w < 10);
        chk("s5_data2_valid", uart_valid, 1);
        chk("s5_data2_byte", uart_data, 8'h00);
        rst = 1'b1;
        @(negedge clk);
        chk("s5_rst_valid", uart_valid, 0);
        chk("s5_rst_busy", busy, 0);
        rst = 1'b0;
        m_ptr = 0; m_last = 8'h00;
        new_scn();
        set_req(1, 8'h80, 8'h3C, 8'h00, 2'd3);
        model_burst(4'b0010);
        req_valid = 4'b0010;
        run(exp_bytes.size());
        settle();
        lit("s5_restart_status", 0, 8'h80);
        chk("s5_count", act_bytes.size(), 3);

        // Zero length real-time message, then a stray uart_done while idle
        new_scn();
        set_req(3, 8'hFE, 8'h11, 8'h22, 2'd0);
        model_burst(4'b1000);
        req_valid = 4'b1000;
        run(exp_bytes.size());
        settle();
        lit("s6_fe", 0, 8'hFE);
        chk("s6_count", act_bytes.size(), 1);
        @(negedge clk); uart_done = 1'b1;
        @(negedge clk); uart_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("spur_busy", busy, 0);
            chk("spur_valid", uart_valid, 0);
            chk("spur_ready", req_ready, 0);
        end
        chk("spur_grant_hold", grant_id, 3);
        new_scn();
        set_req(0, 8'hB0, 8'h07, 8'h7F, 2'd3);
        model_burst(4'b0001);
        req_valid = 4'b0001;
        run(exp_bytes.size());
        settle();
        lit("s6_after_b0", 0, 8'hB0);
        lit("s6_after_b2", 2, 8'h7F);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
